// File: rtl/y86_pkg.sv
// Shared Y86-64 decode definitions: instruction codes, the "no register" marker and
// the source/destination register selection used by the decode stage.
package y86_pkg;

   localparam int unsigned REG_W = 4;
   typedef logic [3:0]       icode_t;
   typedef logic [REG_W-1:0] reg_t;

   localparam icode_t I_HALT   = 4'h0;
   localparam icode_t I_NOP    = 4'h1;
   localparam icode_t I_RRMOVQ = 4'h2;
   localparam icode_t I_IRMOVQ = 4'h3;
   localparam icode_t I_RMMOVQ = 4'h4;
   localparam icode_t I_MRMOVQ = 4'h5;
   localparam icode_t I_OPQ    = 4'h6;
   localparam icode_t I_JXX    = 4'h7;
   localparam icode_t I_CALL   = 4'h8;
   localparam icode_t I_RET    = 4'h9;
   localparam icode_t I_PUSHQ  = 4'hA;
   localparam icode_t I_POPQ   = 4'hB;

   localparam reg_t RNONE      = 4'hF;
   localparam int unsigned DEFAULT_SP_IDX = 4;

   function automatic reg_t sel_src_a(input icode_t icode, input reg_t ra, input reg_t sp);
      case (icode)
         I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: sel_src_a = ra;
         I_RET, I_POPQ:                      sel_src_a = sp;
         default:                            sel_src_a = RNONE;
      endcase
   endfunction

   function automatic reg_t sel_src_b(input icode_t icode, input reg_t rb, input reg_t sp);
      case (icode)
         I_RMMOVQ, I_MRMOVQ, I_OPQ:          sel_src_b = rb;
         I_CALL, I_RET, I_PUSHQ, I_POPQ:     sel_src_b = sp;
         default:                            sel_src_b = RNONE;
      endcase
   endfunction

   function automatic reg_t sel_dst_e(input icode_t icode, input reg_t rb, input reg_t sp);
      case (icode)
         I_RRMOVQ, I_IRMOVQ, I_OPQ:          sel_dst_e = rb;
         I_CALL, I_RET, I_PUSHQ, I_POPQ:     sel_dst_e = sp;
         default:                            sel_dst_e = RNONE;
      endcase
   endfunction

   function automatic reg_t sel_dst_m(input icode_t icode, input reg_t ra);
      case (icode)
         I_MRMOVQ, I_POPQ:                   sel_dst_m = ra;
         default:                            sel_dst_m = RNONE;
      endcase
   endfunction

endpackage

// File: rtl/y86_regfile_2r2w.sv
// Y86-64 register file: two combinational read ports, two write ports at the clock edge.
// Indices outside 0..NREGS-1 (including RNONE) read as zero and are never written.
module y86_regfile_2r2w #(
   parameter int unsigned XLEN   = 64,
   parameter int unsigned NREGS  = 15,
   parameter int unsigned RIDX_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [RIDX_W-1:0] rd_a_idx,
   output logic [XLEN-1:0]   rd_a_val,
   input  logic [RIDX_W-1:0] rd_b_idx,
   output logic [XLEN-1:0]   rd_b_val,
   input  logic [RIDX_W-1:0] wr_e_idx,
   input  logic [XLEN-1:0]   wr_e_val,
   input  logic [RIDX_W-1:0] wr_m_idx,
   input  logic [XLEN-1:0]   wr_m_val
);

   localparam logic [RIDX_W-1:0] LAST = RIDX_W'(NREGS - 1);

   logic [XLEN-1:0] regs [NREGS];

   always_comb begin
      rd_a_val = '0;
      rd_b_val = '0;
      if (rd_a_idx <= LAST) rd_a_val = regs[rd_a_idx];
      if (rd_b_idx <= LAST) rd_b_val = regs[rd_b_idx];
   end

   // Port M is written last so it wins when both ports target the same register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
      end else begin
         if (wr_e_idx <= LAST) regs[wr_e_idx] <= wr_e_val;
         if (wr_m_idx <= LAST) regs[wr_m_idx] <= wr_m_val;
      end
   end

endmodule

// File: rtl/decode_stage_pipe.sv
// Pipelined Y86-64 decode stage: register selection, operand read with E/M/W forwarding,
// load-use stall detection and a single D->E pipeline register with valid/ready handshake.
module decode_stage_pipe
   import y86_pkg::*;
#(
   parameter int unsigned XLEN   = 64,
   parameter int unsigned NREGS  = 15,
   parameter int unsigned RIDX_W = 4,
   parameter int unsigned SP_IDX = DEFAULT_SP_IDX
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_icode,
   input  logic [3:0]        in_ifun,
   input  logic [RIDX_W-1:0] in_rA,
   input  logic [RIDX_W-1:0] in_rB,
   input  logic [XLEN-1:0]   in_valC,
   input  logic [XLEN-1:0]   in_valP,
   input  logic [RIDX_W-1:0] E_dstM,
   input  logic [RIDX_W-1:0] e_dstE,
   input  logic [XLEN-1:0]   e_valE,
   input  logic [RIDX_W-1:0] m_dstM,
   input  logic [XLEN-1:0]   m_valM,
   input  logic [RIDX_W-1:0] M_dstE,
   input  logic [XLEN-1:0]   M_valE,
   input  logic [RIDX_W-1:0] W_dstE,
   input  logic [XLEN-1:0]   W_valE,
   input  logic [RIDX_W-1:0] W_dstM,
   input  logic [XLEN-1:0]   W_valM,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [3:0]        out_icode,
   output logic [3:0]        out_ifun,
   output logic [XLEN-1:0]   out_valA,
   output logic [XLEN-1:0]   out_valB,
   output logic [XLEN-1:0]   out_valC,
   output logic [RIDX_W-1:0] out_srcA,
   output logic [RIDX_W-1:0] out_srcB,
   output logic [RIDX_W-1:0] out_dstE,
   output logic [RIDX_W-1:0] out_dstM,
   output logic              load_use
);

   localparam logic [RIDX_W-1:0] SP = RIDX_W'(SP_IDX);
   localparam logic [RIDX_W-1:0] RN = RNONE;

   logic [RIDX_W-1:0] src_a, src_b, dst_e, dst_m;
   logic [XLEN-1:0]   rf_a, rf_b, fwd_a, fwd_b, val_a;
   logic              capture;

   y86_regfile_2r2w #(
      .XLEN   (XLEN),
      .NREGS  (NREGS),
      .RIDX_W (RIDX_W)
   ) u_regfile (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_a_idx (src_a),
      .rd_a_val (rf_a),
      .rd_b_idx (src_b),
      .rd_b_val (rf_b),
      .wr_e_idx (W_dstE),
      .wr_e_val (W_valE),
      .wr_m_idx (W_dstM),
      .wr_m_val (W_valM)
   );

   // Youngest producer wins; a RNONE source never matches because it short-circuits first.
   function automatic logic [XLEN-1:0] forward(input logic [RIDX_W-1:0] src,
                                               input logic [XLEN-1:0]   rf_val);
      if (src == RN)               forward = '0;
      else if (src == e_dstE)      forward = e_valE;
      else if (src == m_dstM)      forward = m_valM;
      else if (src == M_dstE)      forward = M_valE;
      else if (src == W_dstM)      forward = W_valM;
      else if (src == W_dstE)      forward = W_valE;
      else                         forward = rf_val;
   endfunction

   always_comb begin
      src_a = sel_src_a(in_icode, in_rA, SP);
      src_b = sel_src_b(in_icode, in_rB, SP);
      dst_e = sel_dst_e(in_icode, in_rB, SP);
      dst_m = sel_dst_m(in_icode, in_rA);
      fwd_a = forward(src_a, rf_a);
      fwd_b = forward(src_b, rf_b);
      val_a = (in_icode == I_JXX || in_icode == I_CALL) ? in_valP : fwd_a;
   end

   assign load_use = in_valid && (E_dstM != RN) && ((E_dstM == src_a) || (E_dstM == src_b));
   assign in_ready = !load_use && !flush && (!out_valid || out_ready);
   assign capture  = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         out_valid <= 1'b0;
         out_icode <= I_NOP;
         out_ifun  <= '0;
         out_valA  <= '0;
         out_valB  <= '0;
         out_valC  <= '0;
         out_srcA  <= RN;
         out_srcB  <= RN;
         out_dstE  <= RN;
         out_dstM  <= RN;
      end else if (capture) begin
         out_valid <= 1'b1;
         out_icode <= in_icode;
         out_ifun  <= in_ifun;
         out_valA  <= val_a;
         out_valB  <= fwd_b;
         out_valC  <= in_valC;
         out_srcA  <= src_a;
         out_srcB  <= src_b;
         out_dstE  <= dst_e;
         out_dstM  <= dst_m;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe: operand selection, forwarding priority,
// load-use stall, back-pressure, flush and reset behaviour.
module tb_decode_stage_pipe;

   localparam int unsigned XLEN = 64;
   localparam logic [3:0]  RN   = 4'hF;
   localparam logic [3:0]  SP   = 4'h4;

   logic            clk = 1'b0;
   logic            rst_n, flush, in_valid, in_ready, out_valid, out_ready, load_use;
   logic [3:0]      in_icode, in_ifun, in_rA, in_rB;
   logic [XLEN-1:0] in_valC, in_valP;
   logic [3:0]      E_dstM, e_dstE, m_dstM, M_dstE, W_dstE, W_dstM;
   logic [XLEN-1:0] e_valE, m_valM, M_valE, W_valE, W_valM;
   logic [3:0]      out_icode, out_ifun, out_srcA, out_srcB, out_dstE, out_dstM;
   logic [XLEN-1:0] out_valA, out_valB, out_valC;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   always #5 clk = ~clk;

   decode_stage_pipe #(.XLEN(64), .NREGS(15), .RIDX_W(4), .SP_IDX(4)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_icode(in_icode), .in_ifun(in_ifun), .in_rA(in_rA), .in_rB(in_rB),
      .in_valC(in_valC), .in_valP(in_valP), .E_dstM(E_dstM),
      .e_dstE(e_dstE), .e_valE(e_valE), .m_dstM(m_dstM), .m_valM(m_valM),
      .M_dstE(M_dstE), .M_valE(M_valE), .W_dstE(W_dstE), .W_valE(W_valE),
      .W_dstM(W_dstM), .W_valM(W_valM), .out_valid(out_valid), .out_ready(out_ready),
      .out_icode(out_icode), .out_ifun(out_ifun), .out_valA(out_valA), .out_valB(out_valB),
      .out_valC(out_valC), .out_srcA(out_srcA), .out_srcB(out_srcB), .out_dstE(out_dstE),
      .out_dstM(out_dstM), .load_use(load_use)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      flush = 0; in_valid = 0; out_ready = 1;
      in_icode = 4'h1; in_ifun = 0; in_rA = RN; in_rB = RN; in_valC = 0; in_valP = 0;
      E_dstM = RN; e_dstE = RN; m_dstM = RN; M_dstE = RN; W_dstE = RN; W_dstM = RN;
      e_valE = 0; m_valM = 0; M_valE = 0; W_valE = 0; W_valM = 0;
   endtask

   task automatic instr(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                        input logic [63:0] vc, input logic [63:0] vp);
      in_valid = 1; in_icode = ic; in_ifun = 0; in_rA = ra; in_rB = rb; in_valC = vc; in_valP = vp;
   endtask

   initial begin
      idle();
      rst_n = 0;
      tick(); tick();
      rst_n = 1;
      check_val("rst_valid", out_valid, 0);
      check_val("rst_icode", out_icode, 1);
      check_val("rst_valA",  out_valA, 0);
      check_val("rst_dstE",  out_dstE, RN);
      check_val("rst_srcA",  out_srcA, RN);
      check_val("rst_ready", in_ready, 1);

      // irmovq $5,%rbx retiring through W port E
      W_dstE = 3; W_valE = 5;
      tick();
      idle();
      instr(4'h6, 4'h3, 4'h2, 0, 0);
      #1;
      check_val("opq_lu", load_use, 0);
      tick();
      idle();
      check_val("opq_valid", out_valid, 1);
      check_val("opq_icode", out_icode, 6);
      check_val("opq_valA",  out_valA, 5);
      check_val("opq_valB",  out_valB, 0);
      check_val("opq_dstE",  out_dstE, 2);
      check_val("opq_dstM",  out_dstM, RN);
      check_val("opq_srcB",  out_srcB, 2);

      // e beats M
      e_dstE = 3; e_valE = 7; M_dstE = 3; M_valE = 9;
      instr(4'h2, 4'h3, 4'h1, 0, 0);
      tick();
      idle();
      check_val("prio_e_valA", out_valA, 7);
      check_val("prio_e_dstE", out_dstE, 1);
      check_val("prio_e_srcB", out_srcB, RN);

      // M beats W; both W ports hit reg 3, so M port value 12 lands in regfile
      M_dstE = 3; M_valE = 9; W_dstE = 3; W_valE = 11; W_dstM = 3; W_valM = 12;
      instr(4'h2, 4'h3, 4'h1, 0, 0);
      tick();
      idle();
      check_val("prio_M_valA", out_valA, 9);
      instr(4'h2, 4'h3, 4'h1, 0, 0);
      tick();
      idle();
      check_val("wr_mwins_valA", out_valA, 12);
      tick();
      check_val("drain_valid", out_valid, 0);

      // load-use stall, then capture with memory-stage forwarding
      E_dstM = 2;
      instr(4'h2, 4'h2, 4'h4, 0, 0);
      #1;
      check_val("lu_flag",  load_use, 1);
      check_val("lu_ready", in_ready, 0);
      tick();
      check_val("lu_nocap", out_valid, 0);
      E_dstM = RN; m_dstM = 2; m_valM = 64'h33;
      #1;
      check_val("lu_clear", load_use, 0);
      check_val("lu_ready2", in_ready, 1);
      tick();
      idle();
      check_val("lu_valid", out_valid, 1);
      check_val("lu_valA",  out_valA, 64'h33);
      check_val("lu_dstE",  out_dstE, 4);

      // stack ops with %rsp = 0x100
      W_dstE = SP; W_valE = 64'h100;
      tick();
      idle();
      instr(4'hA, 4'h5, RN, 0, 0);
      tick();
      check_val("push_valB", out_valB, 64'h100);
      check_val("push_dstE", out_dstE, SP);
      check_val("push_srcA", out_srcA, 5);
      instr(4'h8, RN, RN, 64'h40, 64'h20);
      tick();
      check_val("call_valA", out_valA, 64'h20);
      check_val("call_valB", out_valB, 64'h100);
      check_val("call_valC", out_valC, 64'h40);
      instr(4'hB, 4'h6, RN, 0, 0);
      tick();
      idle();
      check_val("pop_dstM", out_dstM, 6);
      check_val("pop_valA", out_valA, 64'h100);
      check_val("pop_dstE", out_dstE, SP);

      // back-pressure for three cycles
      instr(4'h6, 4'h1, 4'h2, 0, 0);
      tick();
      out_ready = 0;
      instr(4'h3, RN, 4'h7, 64'h77, 0);
      for (int i = 0; i < 3; i++) begin
         #1;
         check_val("bp_ready", in_ready, 0);
         tick();
         check_val("bp_icode", out_icode, 6);
         check_val("bp_valid", out_valid, 1);
      end
      out_ready = 1;
      #1;
      check_val("bp_release", in_ready, 1);
      tick();
      idle();
      check_val("bp_next_icode", out_icode, 3);
      check_val("bp_next_dstE",  out_dstE, 7);
      check_val("bp_next_valC",  out_valC, 64'h77);

      // flush while holding a valid entry; regfile write proceeds
      out_ready = 0;
      instr(4'h6, 4'h1, 4'h2, 0, 0);
      tick();
      check_val("fl_pre_valid", out_valid, 1);
      flush = 1; W_dstE = 8; W_valE = 64'h88;
      #1;
      check_val("fl_ready", in_ready, 0);
      tick();
      idle();
      check_val("fl_valid", out_valid, 0);
      check_val("fl_dstE",  out_dstE, RN);
      check_val("fl_icode", out_icode, 1);
      instr(4'h2, 4'h8, 4'h1, 0, 0);
      tick();
      idle();
      check_val("fl_wr_valA", out_valA, 64'h88);

      // reset during a stall
      instr(4'h6, 4'h3, 4'h2, 0, 0);
      tick();
      out_ready = 0;
      instr(4'h2, 4'h1, 4'h5, 0, 0);
      tick();
      rst_n = 0;
      tick();
      rst_n = 1;
      idle();
      check_val("rst2_valid", out_valid, 0);
      check_val("rst2_icode", out_icode, 1);
      check_val("rst2_valA",  out_valA, 0);
      check_val("rst2_srcA",  out_srcA, RN);
      instr(4'h2, 4'h3, 4'h1, 0, 0);
      tick();
      idle();
      check_val("rst2_rf_cleared", out_valA, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
